mesh_terminal_rx: RTL and testbench
===================================

// Module: mesh_terminal_rx
// PURPOSE
// Terminal-side sink for one mesh router output port: drains packets offered on the router's
// pndng/data_out/pop handshake, checks the destination header against this terminal's row/col,
// buffers accepted packets in a local FIFO for a valid/ready consumer, and keeps counters.
// Sits between a mesh terminal output and terminal-side logic (or the monitor-side model).
// PARAMETERS
// pckg_sz     40  packet width in bits (>= 24)
// fifo_depth  4   local receive FIFO depth in entries (power of 2, >= 2)
// ROW_ID      4'd1  this terminal's row
// COL_ID      4'd0  this terminal's column
// BROADCAST   8'hFF  header ID value accepted by every terminal
// PORTS
// clk        in   1        clock, rising edge
// reset      in   1        asynchronous, active-high
// pndng      in   1        router output has a packet; data_out valid while high
// data_out   in   pckg_sz  router output packet (show-ahead)
// pop        out  1        one-cycle pop strobe to the router output FIFO
// rx_data    out  pckg_sz  head of local FIFO
// rx_valid   out  1        local FIFO not empty
// rx_ready   in   1        consumer accepts rx_data when rx_valid && rx_ready
// pkt_count  out  16       packets accepted (saturating)
// err_count  out  16       misrouted packets dropped (saturating)
// err_flag   out  1        sticky: any misroute since reset
// BEHAVIOUR
// - Packet fields: [pckg_sz-1 -: 8] ID/next-jump, [pckg_sz-9 -: 4] row, [pckg_sz-13 -: 4] col,
//   [pckg_sz-17] mode, [pckg_sz-18:0] payload.
// - Accept if ID == BROADCAST, or (row == ROW_ID && col == COL_ID); otherwise misroute.
// - Reset (async): FSM=IDLE, pop=0, FIFO empty, rx_valid=0, rx_data=0, counters=0, err_flag=0.
// - FSM IDLE: if pndng && (FIFO has space, counting same-cycle consumer read) -> POP.
//   POP: pop=1 for exactly one cycle; data_out sampled this edge; -> WAIT.
//   WAIT: pop=0 for one cycle (router pndng/data_out settle) -> IDLE.
//   Max throughput 1 packet / 2 cycles; pop never high on consecutive cycles.
// - On POP edge: accept -> write FIFO, pkt_count+1; misroute -> no write, err_count+1,
//   err_flag=1. Misrouted packets are still popped (never block the router).
// - pop is a registered output; never asserted when pndng=0 or FIFO full.
// - FIFO full: FSM stays in IDLE, pop=0, even if the pending packet would be misrouted.
// - Simultaneous FIFO write and read: both performed, occupancy unchanged; allowed when full
//   only if a read occurs the same cycle.
// - rx_data stable while rx_valid && !rx_ready; order of packets preserved.
// - Counters saturate at 16'hFFFF; no wrap.
// - Pointers wrap modulo fifo_depth; occupancy counter width $clog2(fifo_depth)+1.
// - Reset mid-operation (any state): immediate return to reset values; packet in flight at the
//   POP edge is discarded (router already popped it; not counted).
// - pndng dropping while in WAIT: FSM returns to IDLE and waits, no pop.
// TESTING
// 1. Reset, pndng=1, data_out ID/row/col = 8'h00/1/0 -> pop one cycle; rx_valid next cycle,
//    rx_data equals packet, pkt_count=1.
// 2. Back-to-back 5 pending packets, rx_ready=0 -> exactly 4 pops (FIFO full), pop then held 0;
//    raise rx_ready -> 5th popped, order preserved.
// 3. Packet row=2, col=3 -> popped, not written, err_count=1, err_flag=1, rx_valid stays 0.
// 4. Packet ID=8'hFF, row=3, col=3 -> accepted, pkt_count increments.
// 5. Continuous pndng with rx_ready=1 -> pop pattern 1,0,1,0; never two consecutive pops.
// 6. Assert reset while in WAIT with 2 entries queued -> pop=0, rx_valid=0, counters=0 at once.

Source files
------------

// File: rtl/mesh_terminal_rx.sv
// -----------------------------------------------------------------------------
// mesh_terminal_rx
//
// Terminal-side sink for one mesh router output port. Packets offered on the
// router's pndng/data_out/pop handshake are drained one at a time. Each packet
// header is checked against this terminal's row/col (or the broadcast ID).
// Accepted packets go into a small local FIFO that a valid/ready consumer
// drains. Misrouted packets are popped anyway, so the router never stalls on
// them, and they are counted.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-high
//   pndng      in   1        router output has a packet; data_out valid while high
//   data_out   in   pckg_sz  router output packet (show-ahead)
//   pop        out  1        registered one-cycle pop strobe to the router
//   rx_data    out  pckg_sz  head of the local FIFO (zero when empty)
//   rx_valid   out  1        local FIFO not empty
//   rx_ready   in   1        consumer takes rx_data when rx_valid && rx_ready
//   pkt_count  out  16       accepted packets (saturating)
//   err_count  out  16       misrouted packets dropped (saturating)
//   err_flag   out  1        sticky misroute indicator
//
// Packet layout (MSB first): ID[8] | row[4] | col[4] | mode[1] | payload
// -----------------------------------------------------------------------------
module mesh_terminal_rx #(
  parameter int          pckg_sz    = 40,
  parameter int          fifo_depth = 4,
  parameter logic [3:0]  ROW_ID     = 4'd1,
  parameter logic [3:0]  COL_ID     = 4'd0,
  parameter logic [7:0]  BROADCAST  = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [15:0]        pkt_count,
  output logic [15:0]        err_count,
  output logic               err_flag
);

  localparam int PTR_W = $clog2(fifo_depth);
  localparam int CNT_W = $clog2(fifo_depth) + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(fifo_depth);
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  // Drain FSM. POP is the cycle in which pop is high; the router pops and
  // data_out is sampled on the edge that ends it. WAIT gives the router one
  // cycle to present its next head before we decide again.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             pop_q, pop_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic [15:0]      err_count_q, err_count_d;
  logic             err_flag_q, err_flag_d;

  logic [pckg_sz-1:0] mem_q [fifo_depth];

  // ---------------------------------------------------------------------------
  // Header decode
  // ---------------------------------------------------------------------------
  logic [7:0] hdr_id;
  logic [3:0] hdr_row;
  logic [3:0] hdr_col;
  logic       hdr_accept;

  assign hdr_id     = data_out[pckg_sz-1  -: 8];
  assign hdr_row    = data_out[pckg_sz-9  -: 4];
  assign hdr_col    = data_out[pckg_sz-13 -: 4];
  assign hdr_accept = (hdr_id == BROADCAST) || ((hdr_row == ROW_ID) && (hdr_col == COL_ID));

  // ---------------------------------------------------------------------------
  // FIFO status and handshake terms
  // ---------------------------------------------------------------------------
  logic fifo_empty;
  logic fifo_full;
  logic rd_en;
  logic wr_en;
  logic sample;
  logic has_space;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign rd_en      = !fifo_empty && rx_ready;
  // A consumer read in the deciding cycle frees a slot before the write,
  // which lands one cycle later at the end of POP. Only one packet is ever
  // in flight, so the slot cannot be taken by anything else meanwhile.
  assign has_space  = !fifo_full || rd_en;
  assign sample     = (state_q == ST_POP);
  assign wr_en      = sample && hdr_accept;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE,
      ST_WAIT: begin
        // WAIT re-evaluates pndng itself: if the router has emptied, fall back
        // to IDLE; otherwise the next pop follows, giving 1 packet / 2 cycles.
        if (pndng && has_space) state_d = ST_POP;
        else                    state_d = ST_IDLE;
      end
      ST_POP:  state_d = ST_WAIT;
      default: state_d = ST_IDLE;
    endcase
  end

  // pop is registered: it is high exactly while the FSM sits in POP.
  assign pop_d = (state_d == ST_POP);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    if (sample) begin
      if (hdr_accept) begin
        if (pkt_count_q != CNT_MAX) pkt_count_d = pkt_count_q + 16'd1;
      end else begin
        if (err_count_q != CNT_MAX) err_count_d = err_count_q + 16'd1;
        err_flag_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pop_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pop_q       <= pop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
    end
  end

  // NOTE: the storage array is not reset; an entry is only visible after it
  // has been written, and rx_data is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_out;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pop       = pop_q;
  assign rx_valid  = !fifo_empty;
  assign rx_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;
  assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_mesh_terminal_rx.sv
// -----------------------------------------------------------------------------
// tb_mesh_terminal_rx
//
// Drives mesh_terminal_rx from a queue-based router model and a randomised
// consumer. The reference keeps the accepted packets as a plain queue and the
// counters as integers; the expected pop strobe follows the drain rules
// (never two in a row, only with a pending packet and room in the FIFO).
// -----------------------------------------------------------------------------
module tb_mesh_terminal_rx;

  localparam int P     = 40;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         pndng;
  logic [P-1:0] data_out;
  logic         pop;
  logic [P-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [15:0]  pkt_count;
  logic [15:0]  err_count;
  logic         err_flag;

  mesh_terminal_rx #(
    .pckg_sz(P), .fifo_depth(DEPTH), .ROW_ID(4'd1), .COL_ID(4'd0), .BROADCAST(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pkt_count(pkt_count), .err_count(err_count), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  // Router side: packets waiting at the router output, head first.
  logic [P-1:0] rq[$];
  // Reference: accepted packets in arrival order, plus counters.
  logic [P-1:0] exp_q[$];
  int  exp_pkt, exp_err;
  bit  exp_flag, exp_pop;

  int  checks, failures;
  int  cyc;
  int  dut_pops;
  int  consec_pops;
  bit  prev_pop;
  int  first_pop_cyc, last_pop_cyc;

  function automatic logic [P-1:0] make_pkt(input logic [7:0] id, input logic [3:0] row,
                                            input logic [3:0] col);
    logic [23:0] tail;
    tail = 24'($urandom());
    return {id, row, col, tail};
  endfunction

  function automatic bit accepted(input logic [P-1:0] p);
    logic [7:0] id;
    logic [3:0] row, col;
    id  = p[39:32];
    row = p[31:28];
    col = p[27:24];
    return (id == 8'hFF) || (row == 4'd1 && col == 4'd0);
  endfunction

  function automatic logic [P-1:0] rand_pkt();
    logic [7:0] id;
    logic [3:0] row, col;
    case ($urandom_range(0, 3))
      0:       begin id = 8'hFF; row = 4'($urandom()); col = 4'($urandom()); end
      1:       begin id = 8'($urandom_range(0, 254)); row = 4'd2; col = 4'd3; end
      default: begin id = 8'($urandom_range(0, 254)); row = 4'd1; col = 4'd0; end
    endcase
    return make_pkt(id, row, col);
  endfunction

  task automatic drive_router();
    pndng    = (rq.size() != 0);
    data_out = pndng ? rq[0] : '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pkt  = 0;
    exp_err  = 0;
    exp_flag = 1'b0;
    exp_pop  = 1'b0;
    prev_pop = 1'b0;
  endtask

  // One clock: predict, take the edge, update router and reference, compare.
  task automatic cycle();
    bit           rd, nxt_pop, popped;
    logic [P-1:0] p;
    logic [P-1:0] exp_data;
    rd      = (exp_q.size() != 0) && rx_ready;
    nxt_pop = !exp_pop && pndng && ((exp_q.size() < DEPTH) || rd);
    popped  = pop;
    if (popped) begin
      dut_pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      if (prev_pop) consec_pops++;
    end
    prev_pop = popped;
    @(posedge clk);
    #1;
    cyc++;
    if (rd) void'(exp_q.pop_front());
    if (popped && rq.size() != 0) begin
      p = rq.pop_front();
      if (accepted(p)) begin
        exp_q.push_back(p);
        if (exp_pkt < 65535) exp_pkt++;
      end else begin
        if (exp_err < 65535) exp_err++;
        exp_flag = 1'b1;
      end
    end
    exp_pop = nxt_pop;
    drive_router();

    exp_data = (exp_q.size() != 0) ? exp_q[0] : '0;
    checks += 6;
    if (pop !== exp_pop) begin
      failures++; $display("FAIL pop cyc=%0d got=%b exp=%b", cyc, pop, exp_pop);
    end
    if (rx_valid !== (exp_q.size() != 0)) begin
      failures++; $display("FAIL rx_valid cyc=%0d got=%b exp=%b", cyc, rx_valid, exp_q.size() != 0);
    end
    if (rx_data !== exp_data) begin
      failures++; $display("FAIL rx_data cyc=%0d got=%h exp=%h", cyc, rx_data, exp_data);
    end
    if (pkt_count !== 16'(exp_pkt)) begin
      failures++; $display("FAIL pkt_count cyc=%0d got=%0d exp=%0d", cyc, pkt_count, exp_pkt);
    end
    if (err_count !== 16'(exp_err)) begin
      failures++; $display("FAIL err_count cyc=%0d got=%0d exp=%0d", cyc, err_count, exp_err);
    end
    if (err_flag !== exp_flag) begin
      failures++; $display("FAIL err_flag cyc=%0d got=%b exp=%b", cyc, err_flag, exp_flag);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rq.delete();
    drive_router();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks += 6;
    if (pop !== 1'b0)        begin failures++; $display("FAIL %s pop got=%b exp=0", tag, pop); end
    if (rx_valid !== 1'b0)   begin failures++; $display("FAIL %s rx_valid got=%b exp=0", tag, rx_valid); end
    if (rx_data !== '0)      begin failures++; $display("FAIL %s rx_data got=%h exp=0", tag, rx_data); end
    if (pkt_count !== 16'd0) begin failures++; $display("FAIL %s pkt_count got=%0d exp=0", tag, pkt_count); end
    if (err_count !== 16'd0) begin failures++; $display("FAIL %s err_count got=%0d exp=0", tag, err_count); end
    if (err_flag !== 1'b0)   begin failures++; $display("FAIL %s err_flag got=%b exp=0", tag, err_flag); end
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 200;
    rx_ready = 1'b1;
    while ((rq.size() != 0 || exp_q.size() != 0) && budget > 0) begin
      cycle();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL %s drain_timeout router_left=%0d fifo_left=%0d exp=0", tag, rq.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rx_ready = 1'b0;
    rq.delete();
    drive_router();
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("reset_hold");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_single_accept();
    int base;
    base = dut_pops;
    rx_ready = 1'b0;
    rq.push_back(make_pkt(8'h00, 4'd1, 4'd0));
    drive_router();
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (dut_pops - base !== 1) begin
      failures++; $display("FAIL single_pops got=%0d exp=1", dut_pops - base);
    end
    drain("single");
  endtask

  task automatic test_backpressure();
    int base;
    do_reset();
    rx_ready = 1'b0;
    base = dut_pops;
    for (int i = 0; i < 5; i++) rq.push_back(make_pkt(8'($urandom_range(0, 254)), 4'd1, 4'd0));
    drive_router();
    for (int i = 0; i < 14; i++) cycle();
    checks += 2;
    if (dut_pops - base !== 4) begin
      failures++; $display("FAIL full_pops got=%0d exp=4", dut_pops - base);
    end
    if (rq.size() !== 1) begin
      failures++; $display("FAIL full_router_left got=%0d exp=1", rq.size());
    end
    drain("backpressure");
    checks++;
    if (dut_pops - base !== 5) begin
      failures++; $display("FAIL full_total_pops got=%0d exp=5", dut_pops - base);
    end
  endtask

  task automatic test_misroute();
    rx_ready = 1'b0;
    rq.push_back(make_pkt(8'($urandom_range(0, 254)), 4'd2, 4'd3));
    drive_router();
    for (int i = 0; i < 4; i++) cycle();
    checks += 2;
    if (err_flag !== 1'b1) begin
      failures++; $display("FAIL misroute_flag got=%b exp=1", err_flag);
    end
    if (rx_valid !== 1'b0) begin
      failures++; $display("FAIL misroute_valid got=%b exp=0", rx_valid);
    end
  endtask

  task automatic test_broadcast();
    rx_ready = 1'b0;
    rq.push_back(make_pkt(8'hFF, 4'd3, 4'd3));
    drive_router();
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (rx_valid !== 1'b1) begin
      failures++; $display("FAIL broadcast_valid got=%b exp=1", rx_valid);
    end
    drain("broadcast");
  endtask

  task automatic test_back_to_back();
    int base;
    base          = dut_pops;
    consec_pops   = 0;
    first_pop_cyc = -1;
    last_pop_cyc  = -1;
    rx_ready      = 1'b1;
    for (int i = 0; i < 12; i++) rq.push_back(rand_pkt());
    drive_router();
    for (int i = 0; i < 30; i++) cycle();
    checks += 3;
    if (consec_pops !== 0) begin
      failures++; $display("FAIL b2b_consecutive got=%0d exp=0", consec_pops);
    end
    if (dut_pops - base !== 12) begin
      failures++; $display("FAIL b2b_pops got=%0d exp=12", dut_pops - base);
    end
    if (last_pop_cyc - first_pop_cyc !== 22) begin
      failures++; $display("FAIL b2b_span got=%0d exp=22", last_pop_cyc - first_pop_cyc);
    end
  endtask

  task automatic test_random();
    consec_pops = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) rq.push_back(rand_pkt());
      drive_router();
      rx_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain("random");
    checks++;
    if (consec_pops !== 0) begin
      failures++; $display("FAIL random_consecutive got=%0d exp=0", consec_pops);
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    do_reset();
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) rq.push_back(make_pkt(8'h00, 4'd1, 4'd0));
    drive_router();
    budget = 20;
    while (exp_q.size() != 2 && budget > 0) begin
      cycle();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++; $display("FAIL reset_mid_setup_timeout fifo=%0d exp=2", exp_q.size());
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid");
    rq.delete();
    drive_router();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    dut_pops      = 0;
    consec_pops   = 0;
    first_pop_cyc = -1;
    last_pop_cyc  = -1;
    pndng         = 1'b0;
    data_out      = '0;
    rx_ready      = 1'b0;
    reset         = 1'b1;
    test_reset();
    test_single_accept();
    test_backpressure();
    test_misroute();
    test_broadcast();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
